// File: rtl/steer_pkg.sv
// Shared types and constants for the steering-enable sequencer.
//   steer_state_t : rider/steering sequencer states
//   TMR_W         : stance timer width
//   TMR_FAST_W    : timer bits that must be all ones for "full" in fast-sim builds
//   iir_step      : one update of the optional load-cell smoothing filter
package steer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } steer_state_t;

  localparam int unsigned TMR_W       = 26;
  localparam int unsigned TMR_FAST_W  = 15;

  localparam logic [11:0] MIN_RIDER_WT_DEF = 12'h200;
  localparam logic [11:0] WT_HYST_DEF      = 12'h040;

  // avg + ((ld - avg) >>> 2); the arithmetic shift floors, so the average never
  // overshoots the input and stays inside the 12-bit range.
  function automatic logic [11:0] iir_step(input logic [11:0] avg, input logic [11:0] ld);
    logic signed [12:0] dlt;
    logic signed [12:0] stp;
    dlt = $signed({1'b0, ld}) - $signed({1'b0, avg});
    stp = dlt >>> 2;
    return avg + stp[11:0];
  endfunction

endpackage

// File: rtl/steer_tmr.sv
// Saturating stance timer.
//   clk      : system clock
//   rst_n    : synchronous active-low reset
//   clr      : clear count to zero (wins over inc)
//   inc      : advance count by one unless already full
//   tmr_full : FAST_SIM=1 -> low TMR_FAST_W bits all ones; FAST_SIM=0 -> all bits ones
module steer_tmr
  import steer_pkg::*;
#(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tmr_full
);

  logic [TMR_W-1:0] cnt_q;

  always_comb begin
    if (FAST_SIM) begin
      tmr_full = &cnt_q[TMR_FAST_W-1:0];
    end else begin
      tmr_full = &cnt_q;
    end
  end

  // Holds at full rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !tmr_full) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/steer_en_ctrl.sv
// Rider-presence and steering-enable sequencer for the balance controller.
// Watches the platform load cells; steering is enabled only after a stable,
// balanced stance has been held for the stance timer window.
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   vld       : one-cycle strobe, new lft_ld/rght_ld sample
//   lft_ld    : left load cell, unsigned 12 bit
//   rght_ld   : right load cell, unsigned 12 bit
//   en_steer  : steering enabled (registered)
//   rider_off : no rider, clears PID integrator (registered)
// Build option: define STEER_LD_AVG_EN to replace raw sample capture with a
// per-side IIR average (avg += (ld - avg) >>> 2 on each vld).
module steer_en_ctrl
  import steer_pkg::*;
#(
  parameter bit          FAST_SIM     = 1'b1,
  parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
  parameter logic [11:0] WT_HYST      = WT_HYST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        en_steer,
  output logic        rider_off
);

  localparam logic [12:0] ThrHi = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
  localparam logic [12:0] ThrLo = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

  logic [11:0]  lft_q, rght_q;
  logic [12:0]  sum, diff;
  logic         sum_hi, sum_lo, diff_q, diff_big;
  logic         tmr_clr, tmr_inc, tmr_full;
  steer_state_t state, nxt;

  // Sample registers
`ifdef STEER_LD_AVG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lft_q  <= '0;
      rght_q <= '0;
    end else if (vld) begin
      lft_q  <= iir_step(lft_q, lft_ld);
      rght_q <= iir_step(rght_q, rght_ld);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lft_q  <= '0;
      rght_q <= '0;
    end else if (vld) begin
      lft_q  <= lft_ld;
      rght_q <= rght_ld;
    end
  end
`endif

  // Stance evaluation, every clock on the held samples.
  always_comb begin
    sum = {1'b0, lft_q} + {1'b0, rght_q};
    if (lft_q >= rght_q) begin
      diff = {1'b0, lft_q - rght_q};
    end else begin
      diff = {1'b0, rght_q - lft_q};
    end
    sum_hi   = sum > ThrHi;
    sum_lo   = sum < ThrLo;
    // Moderate imbalance restarts the settle window; only a near one-footed
    // stance (diff close to the whole sum) drops steering.
    diff_q   = diff > (sum >> 2);
    diff_big = diff > (sum - (sum >> 4));
  end

  steer_tmr #(
    .FAST_SIM (FAST_SIM)
  ) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .inc      (tmr_inc),
    .tmr_full (tmr_full)
  );

  always_comb begin
    nxt     = state;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    unique case (state)
      IDLE: begin
        tmr_clr = 1'b1;
        if (sum_hi) begin
          nxt = WAIT;
        end
      end
      WAIT: begin
        if (sum_lo) begin
          nxt     = IDLE;
          tmr_clr = 1'b1;
        end else if (diff_q) begin
          tmr_clr = 1'b1;
        end else if (tmr_full) begin
          nxt = STEER;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      STEER: begin
        if (sum_lo) begin
          nxt     = IDLE;
          tmr_clr = 1'b1;
        end else if (diff_big) begin
          nxt     = WAIT;
          tmr_clr = 1'b1;
        end
      end
      default: begin
        nxt     = IDLE;
        tmr_clr = 1'b1;
      end
    endcase
  end

  // Outputs decode the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      en_steer  <= 1'b0;
      rider_off <= 1'b1;
    end else begin
      state     <= nxt;
      en_steer  <= (nxt == STEER);
      rider_off <= (nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_steer_en_ctrl.sv
module tb_steer_en_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic [11:0] lft_ld, rght_ld;
  logic        en_steer, rider_off;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  steer_en_ctrl #(
    .FAST_SIM     (1'b1),
    .MIN_RIDER_WT (12'h200),
    .WT_HYST      (12'h040)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld       (vld),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .en_steer  (en_steer),
    .rider_off (rider_off)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: rider present above 0x240, gone below 0x1C0; a stance
  // is "settled" once it has stayed balanced for 2^15 clocks.
  int m_l = 0, m_r = 0;
  int phase = 0;       // 0 no rider, 1 settling, 2 steering
  int settled = 0;     // clocks of balanced stance so far
  bit exp_rider = 1'b1, exp_en = 1'b0;

  always @(posedge clk) begin
    int s, d;
    if (!rst_n) begin
      phase = 0; settled = 0; m_l = 0; m_r = 0;
    end else begin
      s = m_l + m_r;
      d = (m_l > m_r) ? m_l - m_r : m_r - m_l;
      if (phase == 0) begin
        settled = 0;
        if (s > 'h240) phase = 1;
      end else if (s < 'h1C0) begin
        phase = 0; settled = 0;
      end else if (phase == 1) begin
        if (4 * d > s - (s % 4)) settled = 0;
        else if (settled == 32767) phase = 2;
        else settled++;
      end else if (d > s - s / 16) begin
        phase = 1; settled = 0;
      end
      if (vld) begin
`ifdef STEER_LD_AVG_EN
        m_l = m_l + ((int'(lft_ld) - m_l) >>> 2);
        m_r = m_r + ((int'(rght_ld) - m_r) >>> 2);
`else
        m_l = int'(lft_ld);
        m_r = int'(rght_ld);
`endif
      end
    end
    exp_rider = (phase == 0);
    exp_en    = (phase == 2);
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_rider_off", rider_off, exp_rider);
      check("model_en_steer", en_steer, exp_en);
    end
  end

  task automatic drive(input logic [11:0] l, input logic [11:0] r);
    vld = 1'b1; lft_ld = l; rght_ld = r;
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic wait_en(input string name, input int lo, input int hi);
    int cyc = 0;
    while (!en_steer && cyc < 33000) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_in_window"}, (cyc >= lo && cyc <= hi), 1);
  endtask

  initial begin
    rst_n = 1'b0; vld = 1'b0; lft_ld = '0; rght_ld = '0;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    check("rst_rider_off", rider_off, 1);
    check("rst_en_steer", en_steer, 0);
    rst_n = 1'b1;

`ifdef STEER_LD_AVG_EN
    drive(12'h200, 12'h200);
    check("avg1_model", m_l, 'h080);
    check("avg1_dut", dut.lft_q, 'h080);
    drive(12'h200, 12'h200);
    check("avg2_model", m_l, 'h0E0);
    check("avg2_dut", dut.lft_q, 'h0E0);
    drive(12'h200, 12'h200);
    check("avg3_model", m_r, 'h128);
    check("avg3_dut", dut.rght_q, 'h128);
    repeat (5) drive(12'h200, 12'h200);
    repeat (200) @(negedge clk);
`else
    repeat (100) @(negedge clk);
    check("idle_rider_off", rider_off, 1);
    check("idle_en_steer", en_steer, 0);

    // Rider steps on, balanced.
    drive(12'h180, 12'h180);
    @(negedge clk);
    check("on_rider_off", rider_off, 0);
    check("on_en_steer", en_steer, 0);

    // Imbalance while settling restarts the window.
    repeat (50) @(negedge clk);
    drive(12'h300, 12'h100);
    repeat (20) @(negedge clk);
    check("imbal_en_steer", en_steer, 0);
    check("imbal_rider_off", rider_off, 0);
    check("imbal_tmr_zero", dut.u_tmr.cnt_q, 0);
    drive(12'h180, 12'h180);
    wait_en("settle1", 32767, 32769);

    // Near one-footed stance drops back to settling.
    repeat (5) @(negedge clk);
    drive(12'h3F0, 12'h010);
    @(negedge clk);
    check("onefoot_en_steer", en_steer, 0);
    check("onefoot_rider_off", rider_off, 0);
    drive(12'h180, 12'h180);
    wait_en("settle2", 32767, 32769);

    // Hysteresis band holds, below band drops the rider.
    drive(12'h0F8, 12'h0F8);
    @(negedge clk);
    check("band_en_steer", en_steer, 1);
    check("band_rider_off", rider_off, 0);
    drive(12'h0D0, 12'h0D0);
    @(negedge clk);
    check("low_rider_off", rider_off, 1);
    check("low_en_steer", en_steer, 0);
    drive(12'h0F8, 12'h0F8);
    repeat (3) @(negedge clk);
    check("band_idle_rider_off", rider_off, 1);

    // Reset while steering.
    drive(12'h180, 12'h180);
    wait_en("settle3", 32767, 32770);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_en_steer", en_steer, 0);
    check("midrst_rider_off", rider_off, 1);
    check("midrst_tmr_zero", dut.u_tmr.cnt_q, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_rider_off", rider_off, 1);
`endif

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
